// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned WORD_BYTES        = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_ready marks the cycle
// the final byte arrives, with the completed word presented on 'word'.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam int unsigned IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0] byte_idx;
  logic [31:0]      lanes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (byte_valid) begin
      lanes[{byte_idx, 3'b000} +: 8] <= byte_data;
      byte_idx <= byte_idx + 1'b1;
    end
  end

  // Merge the in-flight byte so the full word is available in its arrival cycle.
  always_comb begin
    word = lanes;
    word[{byte_idx, 3'b000} +: 8] = byte_data;
  end

  assign word_ready = byte_valid && (byte_idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Framed serial program loader: sync, count, little-endian words, writes to imem.
// Optional trailing XOR checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH          = 32,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t    state, state_nx;
  logic [IDX_W-1:0] word_idx, word_cnt;
  logic [TMO_W-1:0] idle_cnt;
  logic             sync_seen, in_packet, timed_out, count_ok, last_word;
  logic             asm_valid, word_ready;
  logic [31:0]      word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       checksum;
`endif

  assign sync_seen = rx_valid && (rx_data == SYNC_BYTE) &&
                     (state == IDLE || state == DONE || state == ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_packet = (state == COUNT) || (state == DATA) || (state == CHECK);
`else
  assign in_packet = (state == COUNT) || (state == DATA);
`endif
  assign timed_out = in_packet && !rx_valid && (idle_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign count_ok  = (rx_data != 8'd0) && (32'(rx_data) <= DEPTH);
  assign asm_valid = rx_valid && (state == DATA);
  assign last_word = word_ready && (word_idx == word_cnt - 1'b1);

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (sync_seen),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERROR: if (sync_seen) state_nx = COUNT;
      COUNT:             if (rx_valid) state_nx = count_ok ? DATA : ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      DATA:              if (last_word) state_nx = CHECK;
      CHECK:             if (rx_valid) state_nx = (rx_data == checksum) ? DONE : ERROR;
`else
      DATA:              if (last_word) state_nx = DONE;
`endif
      default:           state_nx = IDLE;
    endcase
    if (timed_out) state_nx = ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_idx   <= '0;
      word_cnt   <= '0;
      idle_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (word_ready) begin
        imem_we    <= 1'b1;
        imem_addr  <= 32'(word_idx) << 2;
        imem_wdata <= word;
        word_idx   <= word_idx + 1'b1;
      end

      // A new sync takes priority over the sticky DONE/ERROR status.
      if (sync_seen) begin
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        word_idx   <= '0;
      end else if (state == DONE) begin
        cpu_hold   <= 1'b0;
        load_done  <= 1'b1;
      end else if (state == ERROR) begin
        load_error <= 1'b1;
      end

      if (state == COUNT && rx_valid) word_cnt <= IDX_W'(rx_data);

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (sync_seen)      checksum <= '0;
      else if (asm_valid) checksum <= checksum ^ rx_data;
`endif

      if (!in_packet || rx_valid) idle_cnt <= '0;
      else if (!timed_out)        idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a packet-level model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned TMO   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        cpu_hold, load_done, load_error;

  imem_loader #(
    .DEPTH          (DEPTH),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hold_gaps = 0;
  logic [63:0] wq[$];
  logic [31:0] pw[DEPTH];

  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back({imem_addr, imem_wdata});
      if (!cpu_hold) hold_gaps++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] xor_fold(input int n);
    logic [31:0] acc = '0;
    for (int i = 0; i < n; i++) acc ^= pw[i];
    return acc[31:24] ^ acc[23:16] ^ acc[15:8] ^ acc[7:0];
  endfunction

  task automatic send_packet(input int n, input bit bad_ck, input int max_gap);
    logic [7:0] nb;
    nb = n[7:0];
    send(8'hA5);
    idle($urandom_range(0, max_gap));
    send(nb);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, max_gap));
        send(pw[i][8*b +: 8]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
    idle($urandom_range(0, max_gap));
    send(bad_ck ? ~xor_fold(n) : xor_fold(n));
`else
    if (bad_ck) $display("note: checksum disabled, corruption ignored");
`endif
  endtask

  // Expected outcome: n_wr sequential word writes from pw[], then done or error.
  task automatic check_load(input string tag, input int n_wr, input bit ok);
    idle(4);
    chk({tag, "_nwrites"}, 64'(wq.size()), 64'(n_wr));
    for (int i = 0; i < n_wr && i < wq.size(); i++)
      chk({tag, "_write"}, wq[i], {32'(i * 4), pw[i]});
    chk({tag, "_flags"}, {61'd0, cpu_hold, load_done, load_error},
        {61'd0, !ok, ok, !ok});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    chk("reset_outputs", {imem_addr, imem_wdata},  64'd0);
    chk("reset_flags", {60'd0, imem_we, cpu_hold, load_done, load_error}, 64'd0);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int n;
    bit bad;
    do_reset();

    // Directed good 2-word load with exact write and hold timing.
    wq.delete();
    pw[0] = 32'h00A00093;
    pw[1] = 32'h01400113;
    send(8'hA5);
    chk("hold_after_sync", 64'(cpu_hold), 64'd1);
    send(8'h02);
    send(8'h93); send(8'h00); send(8'hA0); send(8'h00);
    chk("w0_port", {31'd0, imem_we, imem_addr}, {31'd0, 1'b1, 32'h0});
    chk("w0_data", 64'(imem_wdata), 64'h00A00093);
    send(8'h13); send(8'h01); send(8'h40); send(8'h01);
    chk("w1_port", {31'd0, imem_we, imem_addr}, {31'd0, 1'b1, 32'h4});
    chk("w1_data", 64'(imem_wdata), 64'h01400113);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h60);
`endif
    chk("hold_before_release", 64'(cpu_hold), 64'd1);
    idle(1);
    chk("release", {62'd0, cpu_hold, load_done}, {62'd0, 1'b0, 1'b1});
    check_load("good2", 2, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wq.delete();
    send_packet(2, 1'b1, 0);
    check_load("badck", 2, 1'b0);
`endif

    // Illegal counts.
    wq.delete();
    send(8'hA5); send(8'h00);
    idle(3);
    chk("count0_err", {62'd0, cpu_hold, load_error}, {62'd0, 2'b11});
    send(8'hA5);
    chk("sync_clears_err", 64'(load_error), 64'd0);
    send(8'h21);
    idle(3);
    chk("count33_err", {62'd0, cpu_hold, load_error}, {62'd0, 2'b11});
    chk("illegal_nwrites", 64'(wq.size()), 64'd0);

    // Timeout with a partial word.
    wq.delete();
    send(8'hA5); send(8'h01); send(8'h93); send(8'h00);
    idle(TMO - 10);
    chk("tmo_early", 64'(load_error), 64'd0);
    idle(20);
    chk("tmo_err", {62'd0, cpu_hold, load_error}, {62'd0, 2'b11});
    chk("tmo_nwrites", 64'(wq.size()), 64'd0);

    // Noise, back-to-back strobes, async reset mid-DATA.
    do_reset();
    send(8'h7F); send(8'h00);
    chk("noise_ignored", 64'(cpu_hold), 64'd0);
    send(8'hA5);
    chk("b2b_sync", 64'(cpu_hold), 64'd1);
    send(8'h03);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    rst_n = 1'b0;
    #2;
    chk("async_rst", {imem_addr, imem_wdata}, 64'd0);
    chk("async_rst_flags", {60'd0, imem_we, cpu_hold, load_done, load_error}, 64'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    wq.delete();
    n = $urandom_range(1, DEPTH);
    for (int i = 0; i < n; i++) pw[i] = $urandom;
    send_packet(n, 1'b0, 2);
    check_load("after_rst", n, 1'b1);

    // Full depth, back-to-back.
    wq.delete();
    for (int i = 0; i < DEPTH; i++) pw[i] = $urandom;
    send_packet(DEPTH, 1'b0, 0);
    check_load("full_depth", DEPTH, 1'b1);

    // Randomized packets.
    for (int k = 0; k < 6; k++) begin
      wq.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) pw[i] = $urandom;
`ifdef IMEM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      send_packet(n, bad, 3);
      check_load("random", n, !bad);
    end

    chk("hold_during_writes", 64'(hold_gaps), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
